// File: rtl/jvn_ctrl_if.sv
// rtl/jvn_ctrl_if.sv - memory address/write-enable bus between jvn_ctrl and the shared 256x8 memory
interface jvn_ctrl_if;
  logic [7:0] address;
  logic       we;

  modport master (output address, output we);
  modport slave  (input  address, input  we);
endinterface

// File: rtl/jvn_ctrl.sv
// rtl/jvn_ctrl.sv - fetch/execute controller for the 8-bit accumulator ISA (optional JZ via JVN_JZ_EN)
module jvn_ctrl #(
  parameter logic [3:0] DATA_PAGE = 4'hF,
  parameter logic [7:0] RESET_PC  = 8'h00
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       run,
  jvn_ctrl_if.master mem,
  inout  wire  [7:0] data,
  output logic [7:0] pc,
  output logic [7:0] acc,
  output logic       carry,
  output logic       halted
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_HALT  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_ADD   = 3'b101;
`ifdef JVN_JZ_EN
  localparam logic [2:0] OP_JZ    = 3'b110;
`endif

  state_t     state;
  logic [7:0] ir;
  logic [2:0] opcode;
  logic       is_jmp;
  logic       is_data_op;
  logic       we_int;
  logic [8:0] sum;
  logic [8:0] diff;

  assign is_jmp = ir[7];
  assign opcode = ir[6:4];

  // Decode which instructions put a data-page operand on the address bus
  always_comb begin
    is_data_op = 1'b0;
    if (!is_jmp) begin
      case (opcode)
        OP_SUB, OP_STORE, OP_LOAD, OP_ADD: is_data_op = 1'b1;
        default:                           is_data_op = 1'b0;
      endcase
    end
  end

  // Write strobe follows state directly so an async reset drops it at once
  assign we_int = (state == EXEC) && !is_jmp && (opcode == OP_STORE);
  assign mem.we = we_int;

  // Operand address during data-op EXEC, otherwise the program counter
  always_comb begin
    mem.address = pc;
    if (state == EXEC && is_data_op) mem.address = {DATA_PAGE, ir[3:0]};
  end

  // Accumulator drives the shared bus only while writing
  assign data = we_int ? acc : 8'hzz;

  // Nine-bit results; bit 8 is carry-out for ADD and borrow for SUB
  assign sum  = {1'b0, acc} + {1'b0, data};
  assign diff = {1'b0, acc} - {1'b0, data};

  // Fetch/execute sequencer with architectural state and registered halted flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      ir     <= 8'h00;
      acc    <= 8'h00;
      carry  <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) state <= FETCH;
        end
        FETCH: begin
          ir    <= data;
          pc    <= pc + 8'd1;
          state <= EXEC;
        end
        EXEC: begin
          if (is_jmp) begin
            pc <= {1'b0, ir[6:0]};
          end else begin
            case (opcode)
              OP_SUB: begin
                acc   <= diff[7:0];
                carry <= diff[8];
              end
              OP_LOAD: acc <= data;
              OP_ADD: begin
                acc   <= sum[7:0];
                carry <= sum[8];
              end
`ifdef JVN_JZ_EN
              OP_JZ: begin
                if (acc == 8'h00) pc <= {4'h0, ir[3:0]};
              end
`endif
              default: ;
            endcase
          end
          if (!is_jmp && opcode == OP_HALT) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (run) begin
            state <= FETCH;
          end else begin
            state <= IDLE;
          end
        end
        HALT: begin
          if (!run) begin
            state  <= IDLE;
            halted <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/jvn_ctrl.md
# jvn_ctrl

Fetch/execute controller that sequences the shared 256x8 von Neumann memory (single address bus, bidirectional data bus, write enable). It owns the memory port, holds PC, IR and accumulator, and runs the 8-bit accumulator ISA stored in memory. It sits between the memory and the top level, which only provides run control and observes status.

## Interface
Parameters:
- DATA_PAGE, 4'hF, upper nibble of every data-operand address (operand address = {DATA_PAGE, ir[3:0]})
- RESET_PC, 8'h00, PC value loaded on reset

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = execute, 0 = stop at next instruction boundary
- address  out  8  memory address
- we  out  1  memory write enable (memory writes at rising edge while we=1)
- data  inout  8  memory data; driven with acc only while we=1, else high-Z
- pc  out  8  program counter
- acc  out  8  accumulator
- carry  out  1  carry/borrow flag
- halted  out  1  1 while in HALT state

## Operation
- Instruction format: bit7=1 → JMP, target = {1'b0, ir[6:0]}. bit7=0 → opcode ir[6:4], operand ir[3:0].
- Opcodes: 000 NOP; 001 SUB (acc ← acc − M[op], carry ← borrow); 010 HALT; 011 STORE (M[op] ← acc); 100 LOAD (acc ← M[op], carry unchanged); 101 ADD (acc ← acc + M[op], carry ← bit 8); 110 JZ (see Configuration); 111 NOP.
- States: IDLE, FETCH, EXEC, HALT.
  - IDLE: run=1 → FETCH; else stay.
  - FETCH: address=pc; IR ← data; pc ← pc+1 (8-bit wrap, 255→0) → EXEC.
  - EXEC: address={DATA_PAGE, ir[3:0]} for LOAD/ADD/SUB/STORE, else pc. Result committed at edge. Next: HALT if opcode HALT; else FETCH if run=1; else IDLE.
  - HALT: halted=1; run=0 → IDLE; stays while run=1. Re-asserting run resumes at pc (instruction after HALT).
- we = (state==EXEC && opcode==STORE && bit7==0); purely combinational from state/IR.
- address in IDLE/HALT = pc.
- Arithmetic modulo 256; ADD/SUB are the only carry writers.

## Timing
- Memory read is combinational; controller samples data at the edge closing FETCH/EXEC.
- Every instruction takes exactly 2 cycles (FETCH+EXEC), including JMP, NOP, HALT.
- run sampled only in IDLE, EXEC and HALT; dropping run mid-instruction completes that instruction, then enters IDLE.
- Reset values: state=IDLE, pc=RESET_PC, ir=8'h00, acc=0, carry=0, halted=0, we=0, address=RESET_PC, data=high-Z.
- Reset asserted during a STORE EXEC forces we=0 immediately; no write occurs.
- JMP/JZ-taken overrides the pc+1 of the preceding FETCH; pc updated at end of EXEC.

## Configuration
- JVN_JZ_EN defined: opcode 110 is JZ; if acc==0 at EXEC, pc ← {4'h0, ir[3:0]}; else pc unchanged.
- JVN_JZ_EN undefined: opcode 110 decodes as NOP; no JZ logic synthesized.

## Test plan
- Program 8'h40,8'h51,8'h32,8'h41,8'h30,8'h42,8'h31,8'h80, M[240]=0, M[241]=1, run=1 from reset → after 1+5×16 edges: M[240]=5, M[241]=8, pc=0, state FETCH.
- M[240]=8'hFF, M[241]=1, program LOAD 0, ADD 1, STORE 2, HALT → acc=0, carry=1, M[242]=0, halted=1 after 9 edges; run 0→1 resumes at pc=4.
- SUB: acc=3, M[op]=5 → acc=8'hFE, carry=1; LOAD afterwards leaves carry=1.
- run dropped during FETCH of STORE → STORE completes (we=1 one cycle), then IDLE; address=pc of next instruction, we=0.
- reset_n low mid-STORE EXEC → we and outputs at reset values same cycle; target memory byte unchanged.
- JZ 8'h65 with acc=0: with JVN_JZ_EN pc=5 after EXEC; without it pc = JZ address+1.
